// File: rtl/pipe_hold_ctrl_pkg.sv
// Shared types for the pipeline hold controller: hold-level encodings, hold bus
// width, controller state enum and the level-saturation helper.
package pipe_hold_ctrl_pkg;

  localparam int HOLD_BUS_W = 3;

  typedef enum logic [HOLD_BUS_W-1:0] {
    HOLD_NONE  = 3'd0,
    HOLD_PC    = 3'd1,
    HOLD_IF    = 3'd2,
    HOLD_ID_EX = 3'd3
  } hold_lvl_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HOLD  = 2'd2
  } ctrl_state_e;

  // Raw request levels above ID_EX are folded onto ID_EX, the deepest hold.
  function automatic hold_lvl_e sat_lvl(input logic [HOLD_BUS_W-1:0] raw);
    return (raw > 3'd3) ? HOLD_ID_EX : hold_lvl_e'(raw);
  endfunction

endpackage

// File: rtl/pipe_hold_ctrl_hold_prio_arb.sv
// Hold arbiter: picks the highest requested hold level among eligible sources,
// breaking ties toward the lowest source index.
module hold_prio_arb
  import pipe_hold_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0]            elig_i,
  input  logic [HOLD_BUS_W*NUM_SRC-1:0] lvl_i,
  output logic                          valid_o,
  output logic [HOLD_BUS_W-1:0]         lvl_o,
  output logic [$clog2(NUM_SRC)-1:0]    idx_o
);

  localparam int IDX_W = $clog2(NUM_SRC);

  hold_lvl_e        best_lvl;
  hold_lvl_e        cur_lvl;
  logic [IDX_W-1:0] best_idx;
  logic             best_vld;

  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
    best_lvl = HOLD_NONE;
    cur_lvl  = HOLD_NONE;
    best_idx = '0;
    best_vld = 1'b0;
    // Strictly-greater compare keeps the first (lowest) index on equal levels.
    for (int k = 0; k < NUM_SRC; k++) begin
      cur_lvl = sat_lvl(lvl_i[HOLD_BUS_W*k +: HOLD_BUS_W]);
      if (elig_i[k] && (cur_lvl > best_lvl)) begin
        best_lvl = cur_lvl;
        best_idx = IDX_W'(k);
        best_vld = 1'b1;
      end
    end
  end

  assign valid_o = best_vld;
  assign lvl_o   = best_lvl;
  assign idx_o   = best_idx;

endmodule

// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/flush controller with per-source watchdog masking.
// Optional build macro PIPE_HOLD_STATS_EN adds the stall_cnt_o statistics port.
module pipe_hold_ctrl
  import pipe_hold_ctrl_pkg::*;
#(
  parameter int NUM_SRC        = 4,
  parameter int FLUSH_CYCLES   = 1,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ADDR_W         = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          jump_flag_i,
  input  logic [ADDR_W-1:0]             jump_addr_i,
  input  logic [NUM_SRC-1:0]            hold_req_i,
  input  logic [HOLD_BUS_W*NUM_SRC-1:0] hold_lvl_i,
  output logic                          jump_flag_o,
  output logic [ADDR_W-1:0]             jump_addr_o,
  output logic [HOLD_BUS_W-1:0]         hold_flag_o,
  output logic [$clog2(NUM_SRC)-1:0]    hold_src_o,
  output logic                          timeout_o,
  output logic [NUM_SRC-1:0]            src_mask_o
`ifdef PIPE_HOLD_STATS_EN
  ,
  output logic [31:0]                   stall_cnt_o
`endif
);

  localparam int SRC_W  = $clog2(NUM_SRC);
  localparam int FCNT_W = 4;
  localparam int WD_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [FCNT_W-1:0] FLUSH_RELOAD = FCNT_W'(FLUSH_CYCLES - 1);
  localparam logic [WD_W-1:0]   WD_TERM      = WD_W'(TIMEOUT_CYCLES - 1);

  ctrl_state_e          state_q, state_d;
  logic [FCNT_W-1:0]    flush_cnt_q, flush_cnt_d;
  logic [WD_W-1:0]      wd_cnt_q, wd_cnt_d;
  logic [NUM_SRC-1:0]   src_mask_q, src_mask_d;
  logic                 timeout_q, timeout_d;

  logic [NUM_SRC-1:0]    elig;
  logic                  arb_valid;
  logic [HOLD_BUS_W-1:0] arb_lvl;
  logic [SRC_W-1:0]      arb_idx;
  logic                  flush_act;
  logic [HOLD_BUS_W-1:0] hold_lvl;
  logic [SRC_W-1:0]      hold_src;
  logic                  wd_term;

  always_comb begin
    elig = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      elig[k] = hold_req_i[k] & ~src_mask_q[k]
              & (hold_lvl_i[HOLD_BUS_W*k +: HOLD_BUS_W] != '0);
    end
  end

  hold_prio_arb #(
    .NUM_SRC (NUM_SRC)
  ) u_arb (
    .elig_i  (elig),
    .lvl_i   (hold_lvl_i),
    .valid_o (arb_valid),
    .lvl_o   (arb_lvl),
    .idx_o   (arb_idx)
  );

  // Flush already sits at the deepest level, so it simply overrides the arbiter.
  assign flush_act = jump_flag_i | (flush_cnt_q != '0);
  assign hold_lvl  = flush_act ? HOLD_ID_EX : arb_lvl;
  assign hold_src  = (arb_valid && (arb_lvl == hold_lvl)) ? arb_idx : '0;

  // A jump in the terminal cycle pre-empts the watchdog.
  assign wd_term = (state_q == ST_HOLD) && (wd_cnt_q == WD_TERM)
                 && arb_valid && !jump_flag_i;

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    if (jump_flag_i) begin
      flush_cnt_d = FLUSH_RELOAD;
      state_d     = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (arb_valid) state_d = ST_HOLD;
        end
        ST_FLUSH: begin
          if (flush_cnt_q != '0) flush_cnt_d = flush_cnt_q - FCNT_W'(1);
          else                   state_d     = arb_valid ? ST_HOLD : ST_IDLE;
        end
        ST_HOLD: begin
          if (!arb_valid) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (jump_flag_i || wd_term || (state_d != ST_HOLD)) wd_cnt_d = '0;
    else if (state_q == ST_HOLD)                         wd_cnt_d = wd_cnt_q + WD_W'(1);
    else                                                 wd_cnt_d = wd_cnt_q;

    src_mask_d = (src_mask_q & hold_req_i)
               | (wd_term ? (NUM_SRC'(1) << arb_idx) : '0);
    timeout_d  = wd_term;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    // NOTE: sequential state uses <= so every register samples the pre-edge values.
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= '0;
      wd_cnt_q    <= '0;
      src_mask_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      wd_cnt_q    <= wd_cnt_d;
      src_mask_q  <= src_mask_d;
      timeout_q   <= timeout_d;
    end
  end

  // Combinational paths are forced quiet while reset is held.
  assign jump_flag_o = rst_n_i & jump_flag_i;
  assign jump_addr_o = (rst_n_i && jump_flag_i) ? jump_addr_i : '0;
  assign hold_flag_o = rst_n_i ? hold_lvl : HOLD_NONE;
  assign hold_src_o  = rst_n_i ? hold_src : '0;
  assign timeout_o   = timeout_q;
  assign src_mask_o  = src_mask_q;

`ifdef PIPE_HOLD_STATS_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_q <= '0;
    end else if ((hold_flag_o != HOLD_NONE) && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Self-checking bench for pipe_hold_ctrl: directed scenarios plus randomized
// traffic, all compared against a cycle-level reference model.
module tb_pipe_hold_ctrl;

  localparam int NSRC = 4;
  localparam int FC   = 3;
  localparam int TC   = 8;
  localparam int AW   = 32;

  logic            clk_i = 1'b0;
  logic            rst_n_i;
  logic            jump_flag_i;
  logic [AW-1:0]   jump_addr_i;
  logic [NSRC-1:0] hold_req_i;
  logic [3*NSRC-1:0] hold_lvl_i;
  logic            jump_flag_o;
  logic [AW-1:0]   jump_addr_o;
  logic [2:0]      hold_flag_o;
  logic [1:0]      hold_src_o;
  logic            timeout_o;
  logic [NSRC-1:0] src_mask_o;
`ifdef PIPE_HOLD_STATS_EN
  logic [31:0]     stall_cnt_o;
`endif

  pipe_hold_ctrl #(
    .NUM_SRC        (NSRC),
    .FLUSH_CYCLES   (FC),
    .TIMEOUT_CYCLES (TC),
    .ADDR_W         (AW)
  ) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .jump_flag_i (jump_flag_i),
    .jump_addr_i (jump_addr_i),
    .hold_req_i  (hold_req_i),
    .hold_lvl_i  (hold_lvl_i),
    .jump_flag_o (jump_flag_o),
    .jump_addr_o (jump_addr_o),
    .hold_flag_o (hold_flag_o),
    .hold_src_o  (hold_src_o),
    .timeout_o   (timeout_o),
    .src_mask_o  (src_mask_o)
`ifdef PIPE_HOLD_STATS_EN
    ,
    .stall_cnt_o (stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state, expressed as plain counters and flags.
  int          m_flush_left;
  bit          m_in_hold;
  int          m_wd;
  bit [NSRC-1:0] m_mask;
  bit          m_timeout;
  int unsigned m_stall;

  bit          m_flush_now;
  bit          any_elig;
  int          exp_flag;
  int          exp_src;

  logic [2:0]      obs_flag;
  logic [1:0]      obs_src;
  logic            obs_timeout;
  logic [NSRC-1:0] obs_mask;
  logic            obs_jf;
  logic [AW-1:0]   obs_addr;

  task automatic model_reset();
    m_flush_left = 0;
    m_in_hold    = 1'b0;
    m_wd         = 0;
    m_mask       = '0;
    m_timeout    = 1'b0;
    m_stall      = 0;
  endtask

  task automatic model_eval();
    int lv[NSRC];
    bit el[NSRC];
    int srcmax;
    m_flush_now = jump_flag_i || (m_flush_left > 0);
    srcmax   = 0;
    any_elig = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      lv[k] = int'(hold_lvl_i[3*k +: 3]);
      if (lv[k] > 3) lv[k] = 3;
      el[k] = hold_req_i[k] && !m_mask[k] && (lv[k] != 0);
      if (el[k]) begin
        any_elig = 1'b1;
        if (lv[k] > srcmax) srcmax = lv[k];
      end
    end
    exp_flag = m_flush_now ? 3 : srcmax;
    exp_src  = 0;
    if ((srcmax != 0) && (srcmax == exp_flag)) begin
      for (int k = NSRC - 1; k >= 0; k--) begin
        if (el[k] && (lv[k] == srcmax)) exp_src = k;
      end
    end
  endtask

  task automatic model_update();
    bit [NSRC-1:0] nmask;
    bit nto;
    if (exp_flag != 0) m_stall++;
    nmask = m_mask & hold_req_i;
    nto   = 1'b0;
    if (jump_flag_i) begin
      m_wd = 0;
    end else if (m_in_hold && any_elig) begin
      if (m_wd == TC - 1) begin
        nto = 1'b1;
        nmask[exp_src] = 1'b1;
        m_wd = 0;
      end else begin
        m_wd++;
      end
    end else begin
      m_wd = 0;
    end
    m_in_hold    = !m_flush_now && any_elig;
    m_flush_left = jump_flag_i ? FC - 1 : ((m_flush_left > 0) ? m_flush_left - 1 : 0);
    m_mask       = nmask;
    m_timeout    = nto;
  endtask

  // One clock: inputs are already applied just after a rising edge.
  task automatic tick();
    model_eval();
    @(negedge clk_i);
    obs_flag    = hold_flag_o;
    obs_src     = hold_src_o;
    obs_timeout = timeout_o;
    obs_mask    = src_mask_o;
    obs_jf      = jump_flag_o;
    obs_addr    = jump_addr_o;
    check("jump_flag", obs_jf, jump_flag_i);
    check("jump_addr", obs_addr, jump_flag_i ? jump_addr_i : '0);
    check("hold_flag", obs_flag, exp_flag);
    check("hold_src", obs_src, exp_src);
    check("timeout", obs_timeout, m_timeout);
    check("src_mask", obs_mask, m_mask);
`ifdef PIPE_HOLD_STATS_EN
    check("stall_cnt", stall_cnt_o, m_stall);
`endif
    model_update();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_jf"}, jump_flag_o, 0);
    check({tag, "_addr"}, jump_addr_o, 0);
    check({tag, "_flag"}, hold_flag_o, 0);
    check({tag, "_src"}, hold_src_o, 0);
    check({tag, "_to"}, timeout_o, 0);
    check({tag, "_mask"}, src_mask_o, 0);
`ifdef PIPE_HOLD_STATS_EN
    check({tag, "_stall"}, stall_cnt_o, 0);
`endif
  endtask

  // Reset pulse starting mid-cycle; released just after an edge.
  task automatic pulse_reset(input string tag);
    #1 rst_n_i = 1'b0;
    #1 check_reset_outputs(tag);
    @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    model_reset();
  endtask

  function automatic logic [3*NSRC-1:0] pack_lvl(input int l0, input int l1, input int l2, input int l3);
    return {3'(l3), 3'(l2), 3'(l1), 3'(l0)};
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "time limit");
  end

  initial begin
    int cnt, last, first_to, pulses;
    logic [NSRC-1:0] to_mask;
    logic [2:0]      to_flag;

    rst_n_i     = 1'b0;
    jump_flag_i = 1'b1;
    jump_addr_i = 32'hDEAD_BEEF;
    hold_req_i  = '1;
    hold_lvl_i  = '1;
    #3 check_reset_outputs("rst_init");
    repeat (2) @(posedge clk_i);
    #1;
    jump_flag_i = 1'b0;
    jump_addr_i = '0;
    hold_req_i  = '0;
    hold_lvl_i  = '0;
    rst_n_i     = 1'b1;
    model_reset();
    tick();

    // Jump passes through in the same cycle and flushes for FC cycles.
    cnt = 0; last = -1;
    for (int i = 0; i < 6; i++) begin
      jump_flag_i = (i == 0);
      jump_addr_i = (i == 0) ? 32'h0000_0100 : 32'h0000_0055;
      tick();
      if (i == 0) begin
        check("jump_pass_flag", obs_jf, 1);
        check("jump_pass_addr", obs_addr, 32'h0000_0100);
      end
      if (i == 1) check("jump_addr_idle", obs_addr, 0);
      if (obs_flag == 3'd3) begin cnt++; last = i; end
    end
    check("flush_len", cnt, 3);
    check("flush_last", last, 2);

    // Priority: higher level wins, ties go to the lower index.
    jump_flag_i = 1'b0;
    jump_addr_i = '0;
    hold_req_i  = 4'b0110;
    hold_lvl_i  = pack_lvl(0, 1, 2, 0);
    tick();
    check("prio_flag", obs_flag, 2);
    check("prio_src", obs_src, 2);
    hold_req_i = 4'b0111;
    hold_lvl_i = pack_lvl(2, 1, 2, 0);
    tick();
    check("prio_tie_src", obs_src, 0);
    hold_req_i = '0;
    repeat (2) tick();

    // Watchdog: source 3 at a saturating level. Request seen in cycle 0,
    // HOLD occupied in cycles 1..8, pulse lands in cycle 9.
    hold_req_i = 4'b1000;
    hold_lvl_i = pack_lvl(0, 0, 0, 7);
    first_to = -1; pulses = 0; to_mask = '0; to_flag = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 0) check("sat_level", obs_flag, 3);
      if (obs_timeout) begin
        pulses++;
        if (first_to < 0) begin first_to = i; to_mask = obs_mask; to_flag = obs_flag; end
      end
    end
    check("wd_cycle", first_to, 9);
    check("wd_pulses", pulses, 1);
    check("wd_mask", to_mask, 4'b1000);
    check("wd_flag", to_flag, 0);
    hold_req_i = '0;
    tick();
    check("mask_hold", obs_mask, 4'b1000);
    tick();
    check("mask_clear", obs_mask, 4'b0000);
    tick();

    // Re-jump in the second flush cycle extends the window.
    cnt = 0; last = -1;
    for (int i = 0; i < 8; i++) begin
      jump_flag_i = (i == 0) || (i == 1);
      jump_addr_i = 32'h0000_0400 + 32'(i);
      tick();
      if (obs_flag == 3'd3) begin cnt++; last = i; end
    end
    check("reflush_len", cnt, 4);
    check("reflush_last", last, 3);

    // Jump on the terminal watchdog cycle: no pulse, counter restarts after flush.
    hold_req_i = 4'b1000;
    hold_lvl_i = pack_lvl(0, 0, 0, 3);
    first_to = -1;
    for (int i = 0; i < 24; i++) begin
      jump_flag_i = (i == 8);
      jump_addr_i = (i == 8) ? 32'h0000_0200 : '0;
      tick();
      if (i == 9) begin
        check("jt_timeout", obs_timeout, 0);
        check("jt_mask", obs_mask, 0);
      end
      if (obs_timeout && (first_to < 0)) first_to = i;
    end
    check("jt_restart", first_to, 20);
    jump_flag_i = 1'b0;
    hold_req_i  = '0;
    repeat (2) tick();

    // Reset in the middle of a hold while a jump is presented.
    hold_req_i = 4'b0100;
    hold_lvl_i = pack_lvl(0, 0, 2, 0);
    repeat (3) tick();
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h0000_0ABC;
    pulse_reset("rst_mid");
    jump_flag_i = 1'b0;
    tick();
    check("post_rst_flag", obs_flag, 2);

    // Randomized traffic with sticky request patterns so watchdogs fire.
    for (int i = 0; i < 1500; i++) begin
      jump_flag_i = ($urandom_range(0, 19) == 0);
      jump_addr_i = $urandom;
      if ($urandom_range(0, 7) == 0) hold_req_i = NSRC'($urandom);
      if ($urandom_range(0, 7) == 0) hold_lvl_i = (3*NSRC)'($urandom);
      if ($urandom_range(0, 499) == 0) pulse_reset("rst_rand");
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
